// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Shared playfield constants, arbiter state type and map helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int MAP_W     = 64;
    localparam int MAP_H     = 44;
    localparam int COORD_W   = 6;
    localparam int MAP_CELLS = MAP_W * MAP_H;
    localparam int MAP_AW    = $clog2(MAP_CELLS);

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        SERVE = 1'b1
    } map_arb_state_t;

    function automatic logic is_border(input logic [COORD_W-1:0] x,
                                       input logic [COORD_W-1:0] y);
        return (x == '0) || (x == COORD_W'(MAP_W - 1)) ||
               (y == '0) || (y == COORD_W'(MAP_H - 1));
    endfunction

    // Row-major cell index, x fastest
    function automatic logic [MAP_AW-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        return MAP_AW'(y) * MAP_AW'(MAP_W) + MAP_AW'(x);
    endfunction

endpackage

`default_nettype wire

// File: rtl/map_ram.sv
// ============================================================================
// Module      : map_ram
// Description : Single-port 1-bit synchronous RAM, read-first, 1-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module map_ram #(
    parameter int DEPTH = 2816,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic          i_we,
    input  logic          i_wdata,
    output logic          o_rdata
);

    logic r_mem [DEPTH];
    logic r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_q <= r_mem[i_addr];
    end

    assign o_rdata = r_q;

endmodule

`default_nettype wire

// File: rtl/map_arbiter.sv
// ============================================================================
// Module      : map_arbiter
// Description : Owns the wall map RAM; initialises it and arbitrates VGA and
//               two game-logic clients. MAP_ARB_RR_EN selects round-robin
//               between clients, otherwise client 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module map_arbiter
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_init,
    output logic        o_init_done,
    input  logic        i_vga_busy,
    input  logic [5:0]  i_vga_x,
    input  logic [5:0]  i_vga_y,
    output logic        o_vga_is_wall,
    input  logic [1:0]  i_req,
    input  logic [1:0]  i_we,
    input  logic [1:0]  i_wdata,
    input  logic [11:0] i_req_x,
    input  logic [11:0] i_req_y,
    output logic [1:0]  o_gnt,
    output logic [1:0]  o_rvalid,
    output logic        o_rdata
);

    map_arb_state_t       r_state, w_state_next;
    logic [COORD_W-1:0]   r_ix, r_iy, w_ix_next, w_iy_next;
    logic [1:0]           r_cand, w_cand_next, w_req, r_rvalid;
    logic                 r_oor, r_vga_rd, r_vga_oor, r_vga_hold;
    logic                 w_serve;
    logic [COORD_W-1:0]   w_cx, w_cy;
    logic                 w_cwe, w_cwdata, w_c_oor, w_vga_oor;
    logic [MAP_AW-1:0]    w_addr;
    logic                 w_we, w_wdata, w_ram_q;

    assign w_serve = (r_state == SERVE);

    // A registered candidate is withdrawn if VGA takes the port this cycle
    assign o_gnt = r_cand & {2{w_serve & ~i_vga_busy}};

    assign w_cx      = o_gnt[1] ? i_req_x[11:6] : i_req_x[5:0];
    assign w_cy      = o_gnt[1] ? i_req_y[11:6] : i_req_y[5:0];
    assign w_cwe     = o_gnt[1] ? i_we[1]    : i_we[0];
    assign w_cwdata  = o_gnt[1] ? i_wdata[1] : i_wdata[0];
    assign w_c_oor   = (w_cy >= COORD_W'(MAP_H));
    assign w_vga_oor = (i_vga_y >= COORD_W'(MAP_H));

    always_comb begin
        w_state_next = r_state;
        w_ix_next    = r_ix;
        w_iy_next    = r_iy;
        w_addr       = '0;
        w_we         = 1'b0;
        w_wdata      = 1'b0;
        case (r_state)
            INIT: begin
                w_addr  = cell_addr(r_ix, r_iy);
                w_we    = 1'b1;
                w_wdata = is_border(r_ix, r_iy);
                if (i_init) begin
                    w_ix_next = '0;
                    w_iy_next = '0;
                end else if (r_ix == COORD_W'(MAP_W - 1)) begin
                    w_ix_next = '0;
                    if (r_iy == COORD_W'(MAP_H - 1)) begin
                        w_iy_next    = '0;
                        w_state_next = SERVE;
                    end else begin
                        w_iy_next = r_iy + COORD_W'(1);
                    end
                end else begin
                    w_ix_next = r_ix + COORD_W'(1);
                end
            end
            SERVE: begin
                if (i_vga_busy) begin
                    w_addr = w_vga_oor ? '0 : cell_addr(i_vga_x, i_vga_y);
                end else if (|o_gnt) begin
                    w_addr  = w_c_oor ? '0 : cell_addr(w_cx, w_cy);
                    w_we    = w_cwe & ~w_c_oor;
                    w_wdata = w_cwdata;
                end
                if (i_init) begin
                    w_state_next = INIT;
                    w_ix_next    = '0;
                    w_iy_next    = '0;
                end
            end
            default: w_state_next = INIT;
        endcase
    end

    assign w_req = i_req & {2{w_serve & ~i_init & ~i_vga_busy}};

`ifdef MAP_ARB_RR_EN
    logic r_last;
    logic w_last_eff;

    // A grant issuing this cycle counts as most recent for the next decision
    assign w_last_eff = (|o_gnt) ? o_gnt[1] : r_last;

    always_comb begin
        w_cand_next = w_req;
        if (&w_req) begin
            w_cand_next = w_last_eff ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end
    end
`else
    always_comb begin
        w_cand_next = w_req;
        if (&w_req) begin
            w_cand_next = 2'b01;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT;
            r_ix       <= '0;
            r_iy       <= '0;
            r_cand     <= '0;
            r_rvalid   <= '0;
            r_oor      <= 1'b0;
            r_vga_rd   <= 1'b0;
            r_vga_oor  <= 1'b0;
            r_vga_hold <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ix       <= w_ix_next;
            r_iy       <= w_iy_next;
            r_cand     <= w_cand_next;
            r_rvalid   <= o_gnt;
            r_oor      <= w_c_oor;
            r_vga_rd   <= w_serve & i_vga_busy;
            r_vga_oor  <= w_vga_oor;
            r_vga_hold <= o_vga_is_wall;
        end
    end

    map_ram #(
        .DEPTH (MAP_CELLS),
        .AW    (MAP_AW)
    ) u_map_ram (
        .clk     (clk),
        .i_addr  (w_addr),
        .i_we    (w_we),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_q)
    );

    // Out-of-range cells read as wall
    assign o_vga_is_wall = w_serve & (r_vga_rd ? (r_vga_oor | w_ram_q) : r_vga_hold);
    assign o_rvalid      = r_rvalid;
    assign o_rdata       = (|r_rvalid) & (r_oor | w_ram_q);
    assign o_init_done   = w_serve;

endmodule

`default_nettype wire

// File: tb/tb_map_arbiter.sv
// ============================================================================
// Module      : tb_map_arbiter
// Description : Directed self-checking bench for map_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_map_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_init;
    logic        o_init_done;
    logic        i_vga_busy;
    logic [5:0]  i_vga_x, i_vga_y;
    logic        o_vga_is_wall;
    logic [1:0]  i_req, i_we, i_wdata;
    logic [11:0] i_req_x, i_req_y;
    logic [1:0]  o_gnt, o_rvalid;
    logic        o_rdata;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    map_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_init        (i_init),
        .o_init_done   (o_init_done),
        .i_vga_busy    (i_vga_busy),
        .i_vga_x       (i_vga_x),
        .i_vga_y       (i_vga_y),
        .o_vga_is_wall (o_vga_is_wall),
        .i_req         (i_req),
        .i_we          (i_we),
        .i_wdata       (i_wdata),
        .i_req_x       (i_req_x),
        .i_req_y       (i_req_y),
        .o_gnt         (o_gnt),
        .o_rvalid      (o_rvalid),
        .o_rdata       (o_rdata)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic client(input int c, input bit we, input bit wd, input int x, input int y);
        i_req[c]           = 1'b1;
        i_we[c]            = we;
        i_wdata[c]         = wd;
        i_req_x[6*c +: 6]  = x[5:0];
        i_req_y[6*c +: 6]  = y[5:0];
    endtask

    // Uncontended request: grant next cycle, response the cycle after
    task automatic txn(input string tag, input int c, input bit we, input bit wd,
                       input int x, input int y, input logic exp_rd);
        logic [1:0] onehot;
        onehot = (c == 0) ? 2'b01 : 2'b10;
        client(c, we, wd, x, y);
        tick();
        check({tag, "_gnt"}, o_gnt, onehot);
        i_req = 2'b00;
        tick();
        check({tag, "_rvalid"}, o_rvalid, onehot);
        check({tag, "_rdata"}, {1'b0, o_rdata}, {1'b0, exp_rd});
    endtask

    task automatic vga_rd(input string tag, input int x, input int y, input logic exp_w);
        i_vga_busy = 1'b1;
        i_vga_x    = x[5:0];
        i_vga_y    = y[5:0];
        tick();
        check(tag, {1'b0, o_vga_is_wall}, {1'b0, exp_w});
    endtask

    initial begin
        logic [1:0] seen;
        logic [1:0] exp_g [4];

        rst_n      = 1'b0;
        i_init     = 1'b0;
        i_vga_busy = 1'b0;
        i_vga_x    = '0;
        i_vga_y    = '0;
        i_req      = '0;
        i_we       = '0;
        i_wdata    = '0;
        i_req_x    = '0;
        i_req_y    = '0;

        tick(2);
        check("rst_init_done", {1'b0, o_init_done}, 2'b00);
        check("rst_vga",       {1'b0, o_vga_is_wall}, 2'b00);
        check("rst_gnt",       o_gnt, 2'b00);
        check("rst_rvalid",    o_rvalid, 2'b00);
        check("rst_rdata",     {1'b0, o_rdata}, 2'b00);

        // Initial map fill with VGA and a client both asking during INIT
        rst_n      = 1'b1;
        i_vga_busy = 1'b1;
        client(0, 1'b0, 1'b0, 1, 1);
        tick(2815);
        check("init_done_early", {1'b0, o_init_done}, 2'b00);
        check("init_no_gnt",     o_gnt, 2'b00);
        check("init_vga_zero",   {1'b0, o_vga_is_wall}, 2'b00);
        tick();
        check("init_done",       {1'b0, o_init_done}, 2'b01);
        i_req = 2'b00;

        vga_rd("vga_0_0",   0,  0, 1'b1);
        vga_rd("vga_5_5",   5,  5, 1'b0);
        vga_rd("vga_10_43", 10, 43, 1'b1);
        vga_rd("vga_9_50",  9,  50, 1'b1);
        vga_rd("vga_63_20", 63, 20, 1'b1);
        i_vga_busy = 1'b0;
        i_vga_x    = 6'd5;
        i_vga_y    = 6'd5;
        tick(2);
        check("vga_hold", {1'b0, o_vga_is_wall}, 2'b01);

        txn("wr_7_9", 0, 1'b1, 1'b1, 7, 9, 1'b0);
        txn("rd_7_9", 1, 1'b0, 1'b0, 7, 9, 1'b1);

        // Same-cycle write then read of one cell
        client(0, 1'b1, 1'b1, 20, 20);
        client(1, 1'b0, 1'b0, 20, 20);
        tick();
        check("raw_gnt0", o_gnt, 2'b01);
        i_req[0] = 1'b0;
        tick();
        check("raw_gnt1",   o_gnt, 2'b10);
        check("raw_rv0",    o_rvalid, 2'b01);
        check("raw_rd0",    {1'b0, o_rdata}, 2'b00);
        i_req[1] = 1'b0;
        tick();
        check("raw_rv1",    o_rvalid, 2'b10);
        check("raw_rd1",    {1'b0, o_rdata}, 2'b01);

        // Both clients request every cycle
`ifdef MAP_ARB_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        client(0, 1'b0, 1'b0, 1, 1);
        client(1, 1'b0, 1'b0, 2, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("both_gnt%0d", i), o_gnt, exp_g[i]);
        end
        i_req = 2'b00;
        tick(3);

        // Client 1 held off by VGA for 100 cycles
        client(1, 1'b0, 1'b0, 3, 0);
        i_vga_busy = 1'b1;
        i_vga_x    = 6'd7;
        i_vga_y    = 6'd9;
        seen       = 2'b00;
        for (int i = 0; i < 100; i++) begin
            tick();
            seen = seen | o_gnt;
        end
        check("busy_no_gnt", seen, 2'b00);
        check("busy_vga_7_9", {1'b0, o_vga_is_wall}, 2'b01);
        i_vga_busy = 1'b0;
        tick();
        check("busy_gnt", o_gnt, 2'b10);
        i_req = 2'b00;
        tick();
        check("busy_rv", o_rvalid, 2'b10);
        check("busy_rd", {1'b0, o_rdata}, 2'b01);

        // VGA rises in the cycle the grant would issue
        client(0, 1'b0, 1'b0, 7, 9);
        tick();
        i_vga_busy = 1'b1;
        #1;
        check("race_no_gnt", o_gnt, 2'b00);
        tick();
        check("race_still_none", o_gnt, 2'b00);
        i_vga_busy = 1'b0;
        tick();
        check("race_gnt", o_gnt, 2'b01);
        i_req = 2'b00;
        tick();
        check("race_rv", o_rvalid, 2'b01);
        check("race_rd", {1'b0, o_rdata}, 2'b01);

        txn("oor_rd",   0, 1'b0, 1'b0, 5, 50, 1'b1);
        txn("oor_wr",   1, 1'b1, 1'b0, 5, 50, 1'b1);
        txn("brd_5_43", 0, 1'b0, 1'b0, 5, 43, 1'b1);
        txn("brd_0_0",  1, 1'b0, 1'b0, 0, 0, 1'b1);

        // Re-init from SERVE, then reset and re-init restarts mid-INIT
        i_init = 1'b1;
        tick();
        i_init = 1'b0;
        check("reinit_drop", {1'b0, o_init_done}, 2'b00);
        tick(500);
        rst_n = 1'b0;
        #1;
        check("rst_mid_init", {1'b0, o_init_done}, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1000);
        i_init = 1'b1;
        tick();
        i_init = 1'b0;
        tick(2815);
        check("reinit_early", {1'b0, o_init_done}, 2'b00);
        tick();
        check("reinit_done",  {1'b0, o_init_done}, 2'b01);

        txn("clr_7_9",   0, 1'b0, 1'b0, 7, 9, 1'b0);
        txn("clr_20_20", 1, 1'b0, 1'b0, 20, 20, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/map_arbiter.md
# map_arbiter

Owns the playfield wall map and schedules every access to it. Single-port map RAM is shared between the VGA renderer (read-only, owns the port while it is scanning the active lines) and two game-logic clients (tank/shell logic for player 1 and 2: wall queries and wall destruction), which are served only during vertical blank. Also sequences map initialisation after reset or on request. Sits between the VGA block, the game FSM and the per-player logic.

## Interface
- MAP_W, 64, grid columns (640 px / 10 px per grid)
- MAP_H, 44, game-area grid rows (48 rows minus 4-row status bar)
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- i_init  in  1  one-cycle pulse: re-initialise map
- o_init_done  out  1  high when map is initialised and serving
- i_vga_busy  in  1  VGA scanning active lines; VGA owns the port
- i_vga_x / i_vga_y  in  6 / 6  VGA grid read address
- o_vga_is_wall  out  1  map bit for VGA address, registered
- i_req  in  2  per-client request, held until granted
- i_we  in  2  per-client write enable
- i_wdata  in  2  per-client write bit (1 = wall)
- i_req_x / i_req_y  in  12 / 12  packed per-client coords, client c at [6c+5:6c]
- o_gnt  out  2  one-hot grant pulse
- o_rvalid  out  2  one-hot response strobe, cycle after grant
- o_rdata  out  1  response bit, valid with o_rvalid

## Operation
- FSM states: INIT, SERVE. Reset → INIT.
- INIT: address counter walks x fastest, then y, over MAP_W*MAP_H cells; writes 1 on border cells (x==0, x==MAP_W-1, y==0, y==MAP_H-1), 0 elsewhere. After last cell (x=63,y=43) → SERVE. No grants; o_vga_is_wall driven 0.
- i_init in SERVE → INIT, counter restarts at (0,0). i_init during INIT restarts counter.
- SERVE, i_vga_busy=1: RAM read at (i_vga_x,i_vga_y) every cycle; no grants.
- SERVE, i_vga_busy=0: at most one client granted per cycle; granted client's access is performed in the grant cycle.
- Client handshake: client raises i_req with we/wdata/x/y stable; holds until o_gnt; may drop or present new request the cycle after o_gnt.
- RAM is read-first: o_rdata returns pre-write value for writes as well as reads.
- Out of range (y ≥ MAP_H): reads return 1 (treated as wall), writes discarded; still granted, still o_rvalid.
- Simultaneous requests: resolved per Configuration.

## Timing
- Reset values: o_init_done=0, o_vga_is_wall=0, o_gnt=0, o_rvalid=0, o_rdata=0; state INIT, counter 0, RR pointer favours client 0.
- o_init_done rises the cycle after the final INIT write; INIT lasts exactly 2816 cycles.
- VGA read latency 1 cycle: o_vga_is_wall(t+1) = map[y][x] sampled at t. Holds last value while i_vga_busy=0.
- o_gnt is registered: request visible at t → earliest o_gnt at t+1 → o_rvalid/o_rdata at t+2 (one-cycle pulses).
- i_vga_busy rising in the same cycle a grant would issue: VGA wins, no grant; request stays pending.
- A write granted in cycle t is visible to any read granted/issued at t+1.
- rst_n asserted mid-INIT or mid-transaction: all in-flight responses dropped, back to INIT.

## Configuration
- MAP_ARB_RR_EN defined: round-robin between clients; on conflict, grant the client not granted last; pointer updates only on grant.
- Not defined: fixed priority, client 0 always wins conflicts (client 1 may starve).

## Structure
- Shared package game_pkg: MAP_W, MAP_H, coordinate width (6), map_arb_state_t enum {INIT, SERVE}, border-cell function.
- Sub-module map_ram: MAP_W*MAP_H x 1 single-port synchronous RAM, read-first, 1-cycle read latency; arbiter/FSM in map_arbiter drives its single address/we/wdata port.

## Test plan
- Reset, wait 2816 cycles → o_init_done=1 on cycle 2817; VGA reads (0,0)=1, (5,5)=1… no: (5,5)=0, (63,20)=1, (10,43)=1.
- i_vga_busy=0, client 0 write (7,9)=1 → o_gnt=01 next cycle, o_rvalid=01 o_rdata=0; then read (7,9) → o_rdata=1.
- Both clients request every cycle, vga idle: RR build alternates grants 01,10,01…; fixed build grants 01 continuously.
- Client 1 request pending while i_vga_busy=1 for 100 cycles → no o_gnt; grant one cycle after i_vga_busy falls; VGA reads unaffected.
- Read y=50 → o_rdata=1; write y=50 with wdata=0 then read (x,43) border → still 1.
- i_init mid-SERVE after write (7,9)=1 → o_init_done drops, 2816 cycles later (7,9) reads 0; rst_n pulse mid-INIT restarts full count.
